// File: rtl/pc_pkg.sv
// Shared op-code encoding for the program counter and its decode source.
package pc_pkg;
  localparam int PC_OP_W = 3;

  localparam logic [PC_OP_W-1:0] PC_OP_HOLD = 3'd0;
  localparam logic [PC_OP_W-1:0] PC_OP_INC  = 3'd1;
  localparam logic [PC_OP_W-1:0] PC_OP_JMP  = 3'd2;
  localparam logic [PC_OP_W-1:0] PC_OP_BRR  = 3'd3;
  localparam logic [PC_OP_W-1:0] PC_OP_CALL = 3'd4;
  localparam logic [PC_OP_W-1:0] PC_OP_RET  = 3'd5;
endpackage

// File: rtl/pc_ras_stack.sv
// Return-address LIFO: DEPTH x WIDTH storage, occupancy count, registered full/empty.
module pc_ras_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    top_idx;
  logic             full_q, empty_q;

  assign top_idx = cnt_q - 1'b1;

  always_comb begin
    cnt_d = cnt_q;
    if (push)     cnt_d = cnt_q + 1'b1;
    else if (pop) cnt_d = cnt_q - 1'b1;
  end

  // Explicit compare mux keeps the read index width independent of DEPTH.
  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++)
      if (top_idx == CW'(i)) dout = mem_q[i];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      if (push && cnt_q == CW'(i)) mem_q[i] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CW'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  assign full  = full_q;
  assign empty = empty_q;
endmodule

// File: rtl/pc_ras.sv
// Fetch-stage program counter with relative branch, hold and CALL/RET return-address stack.
module pc_ras
  import pc_pkg::*;
#(
  parameter int                WIDTH     = 16,
  parameter int                DEPTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VEC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [PC_OP_W-1:0] op,
  input  logic [WIDTH-1:0]   addr,
  input  logic               err_clr,
  output logic [WIDTH-1:0]   out,
  output logic               ras_full,
  output logic               ras_empty,
  output logic               err_ovf,
  output logic               err_unf
);
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_inc, ras_top;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             push, pop, ovf_set, unf_set;

  assign pc_inc = pc_q + 1'b1;

  always_comb begin
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (en) begin
      case (op)
        PC_OP_INC: pc_d = pc_inc;
        PC_OP_JMP: pc_d = addr;
        PC_OP_BRR: pc_d = pc_q + addr;
        PC_OP_CALL: begin
          if (ras_full) ovf_set = 1'b1;
          else begin
            push = 1'b1;
            pc_d = addr;
          end
        end
        PC_OP_RET: begin
          if (ras_empty) unf_set = 1'b1;
          else begin
            pop  = 1'b1;
            pc_d = ras_top;
          end
        end
        default: pc_d = pc_q;
      endcase
    end
  end

  // A fresh error outranks a coincident clear.
  assign ovf_d = ovf_set | (ovf_q & ~err_clr);
  assign unf_d = unf_set | (unf_q & ~err_clr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q  <= RESET_VEC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  pc_ras_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (ras_top),
    .full  (ras_full),
    .empty (ras_empty)
  );

  assign out     = pc_q;
  assign err_ovf = ovf_q;
  assign err_unf = unf_q;
endmodule

// File: tb/tb_pc_ras.sv
// Directed test of pc_ras: counting, stalls, jumps, branches, CALL/RET stack and sticky errors.
module tb_pc_ras;
  import pc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, en, err_clr;
  logic [2:0]  op;
  logic [15:0] addr;
  logic [15:0] out;
  logic        ras_full, ras_empty, err_ovf, err_unf;
  int          total = 0;
  int          bad = 0;

  pc_ras #(.WIDTH(16), .DEPTH(8), .RESET_VEC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .op(op), .addr(addr), .err_clr(err_clr),
    .out(out), .ras_full(ras_full), .ras_empty(ras_empty),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, cross the edge, settle 1ns past it.
  task automatic step(input logic e, input logic [2:0] o, input logic [15:0] a, input logic c);
    en = e; op = o; addr = a; err_clr = c;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b1, PC_OP_HOLD, 16'h0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(1'b1, PC_OP_CALL, 16'h1234, 1'b0);
    rst_n = 1'b1;
    total++;
    if (out !== 16'h0000 || ras_empty !== 1'b1 || ras_full !== 1'b0 ||
        err_ovf !== 1'b0 || err_unf !== 1'b0) begin
      bad++;
      $display("FAIL reset: out=%h empty=%b full=%b ovf=%b unf=%b want 0000 1 0 0 0",
               out, ras_empty, ras_full, err_ovf, err_unf);
    end
  endtask

  task automatic test_inc();
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, PC_OP_INC, 16'h0, 1'b0);
      total++;
      if (out !== 16'(i)) begin
        bad++;
        $display("FAIL inc[%0d]: out=%h want %h", i, out, 16'(i));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, PC_OP_INC, 16'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, PC_OP_INC, 16'h0, 1'b0);
      total++;
      if (out !== 16'h0005) begin
        bad++;
        $display("FAIL stall[%0d]: out=%h want 0005", i, out);
      end
    end
    step(1'b1, PC_OP_INC, 16'h0, 1'b0);
    total++;
    if (out !== 16'h0006) begin
      bad++;
      $display("FAIL stall_resume: out=%h want 0006", out);
    end
  endtask

  task automatic test_jmp_brr();
    logic [15:0] exp_seq [4];
    exp_seq[0] = 16'hFFFE; exp_seq[1] = 16'hFFFF; exp_seq[2] = 16'h0000; exp_seq[3] = 16'h0001;
    step(1'b1, PC_OP_JMP, 16'hFFFE, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step(1'b1, PC_OP_INC, 16'h0, 1'b0);
      total++;
      if (out !== exp_seq[i]) begin
        bad++;
        $display("FAIL jmp_wrap[%0d]: out=%h want %h", i, out, exp_seq[i]);
      end
    end
    step(1'b1, PC_OP_JMP, 16'h0010, 1'b0);
    step(1'b1, PC_OP_BRR, 16'hFFF8, 1'b0);
    total++;
    if (out !== 16'h0008) begin
      bad++;
      $display("FAIL brr_back: out=%h want 0008", out);
    end
    step(1'b1, PC_OP_BRR, 16'h0004, 1'b0);
    total++;
    if (out !== 16'h000C) begin
      bad++;
      $display("FAIL brr_fwd: out=%h want 000c", out);
    end
    step(1'b1, 3'd6, 16'h7777, 1'b0);
    step(1'b1, 3'd7, 16'h7777, 1'b0);
    total++;
    if (out !== 16'h000C) begin
      bad++;
      $display("FAIL reserved_op: out=%h want 000c", out);
    end
  endtask

  task automatic test_call_ret();
    logic [2:0]  ops  [5];
    logic [15:0] args [5];
    logic [15:0] exp_o [5];
    ops[0] = PC_OP_CALL; args[0] = 16'h0200; exp_o[0] = 16'h0200;
    ops[1] = PC_OP_INC;  args[1] = 16'h0;    exp_o[1] = 16'h0201;
    ops[2] = PC_OP_CALL; args[2] = 16'h0300; exp_o[2] = 16'h0300;
    ops[3] = PC_OP_RET;  args[3] = 16'h0;    exp_o[3] = 16'h0202;
    ops[4] = PC_OP_RET;  args[4] = 16'h0;    exp_o[4] = 16'h0101;
    do_reset();
    step(1'b1, PC_OP_JMP, 16'h0100, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, ops[i], args[i], 1'b0);
      total++;
      if (out !== exp_o[i]) begin
        bad++;
        $display("FAIL call_ret[%0d]: out=%h want %h", i, out, exp_o[i]);
      end
    end
    total++;
    if (ras_empty !== 1'b1 || err_unf !== 1'b0) begin
      bad++;
      $display("FAIL call_ret_empty: empty=%b unf=%b want 1 0", ras_empty, err_unf);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, PC_OP_JMP, 16'h0050, 1'b0);
    step(1'b1, PC_OP_CALL, 16'h0060, 1'b0);
    total++;
    if (out !== 16'h0060 || ras_empty !== 1'b0) begin
      bad++;
      $display("FAIL b2b_call: out=%h empty=%b want 0060 0", out, ras_empty);
    end
    step(1'b1, PC_OP_RET, 16'h0, 1'b0);
    total++;
    if (out !== 16'h0051 || ras_empty !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ret: out=%h empty=%b want 0051 1", out, ras_empty);
    end
  endtask

  task automatic test_overflow_underflow();
    logic [15:0] ret_addr [8];
    logic [15:0] pc;
    do_reset();
    step(1'b1, PC_OP_JMP, 16'h1000, 1'b0);
    pc = 16'h1000;
    for (int k = 0; k < 8; k++) begin
      ret_addr[k] = pc + 16'h1;
      pc = 16'h2000 + 16'(k * 16);
      step(1'b1, PC_OP_CALL, pc, 1'b0);
    end
    total++;
    if (ras_full !== 1'b1 || out !== 16'h2070 || err_ovf !== 1'b0) begin
      bad++;
      $display("FAIL fill: full=%b out=%h ovf=%b want 1 2070 0", ras_full, out, err_ovf);
    end
    step(1'b1, PC_OP_CALL, 16'h0ABC, 1'b0);
    total++;
    if (out !== 16'h2070 || err_ovf !== 1'b1 || ras_full !== 1'b1) begin
      bad++;
      $display("FAIL ovf: out=%h ovf=%b full=%b want 2070 1 1", out, err_ovf, ras_full);
    end
    for (int k = 7; k >= 0; k--) begin
      step(1'b1, PC_OP_RET, 16'h0, 1'b0);
      total++;
      if (out !== ret_addr[k] || ras_full !== 1'b0) begin
        bad++;
        $display("FAIL pop[%0d]: out=%h full=%b want %h 0", k, out, ras_full, ret_addr[k]);
      end
    end
    total++;
    if (ras_empty !== 1'b1 || err_unf !== 1'b0 || err_ovf !== 1'b1) begin
      bad++;
      $display("FAIL drained: empty=%b unf=%b ovf=%b want 1 0 1", ras_empty, err_unf, err_ovf);
    end
    step(1'b1, PC_OP_RET, 16'h0, 1'b0);
    total++;
    if (out !== 16'h1001 || err_unf !== 1'b1) begin
      bad++;
      $display("FAIL unf: out=%h unf=%b want 1001 1", out, err_unf);
    end
  endtask

  task automatic test_err_clr();
    step(1'b0, PC_OP_HOLD, 16'h0, 1'b1);
    total++;
    if (err_ovf !== 1'b0 || err_unf !== 1'b0) begin
      bad++;
      $display("FAIL err_clr: ovf=%b unf=%b want 0 0", err_ovf, err_unf);
    end
    for (int k = 0; k < 8; k++) step(1'b1, PC_OP_CALL, 16'h3000 + 16'(k), 1'b0);
    step(1'b1, PC_OP_CALL, 16'h0ABC, 1'b1);
    total++;
    if (err_ovf !== 1'b1 || out !== 16'h3007) begin
      bad++;
      $display("FAIL clr_vs_ovf: ovf=%b out=%h want 1 3007", err_ovf, out);
    end
    step(1'b1, PC_OP_HOLD, 16'h0, 1'b0);
    total++;
    if (err_ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sticky: ovf=%b want 1", err_ovf);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b1, PC_OP_RET, 16'h0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, PC_OP_CALL, 16'h4000 + 16'(k), 1'b0);
    rst_n = 1'b0;
    step(1'b0, PC_OP_CALL, 16'h5555, 1'b0);
    rst_n = 1'b1;
    total++;
    if (out !== 16'h0000 || ras_empty !== 1'b1 || ras_full !== 1'b0 ||
        err_ovf !== 1'b0 || err_unf !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: out=%h empty=%b full=%b ovf=%b unf=%b want 0000 1 0 0 0",
               out, ras_empty, ras_full, err_ovf, err_unf);
    end
    step(1'b1, PC_OP_RET, 16'h0, 1'b0);
    total++;
    if (out !== 16'h0000 || err_unf !== 1'b1) begin
      bad++;
      $display("FAIL ret_after_reset: out=%h unf=%b want 0000 1", out, err_unf);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; op = PC_OP_HOLD; addr = '0; err_clr = 1'b0;
    #1;
    test_reset();
    test_inc();
    test_stall();
    test_jmp_brr();
    test_call_ret();
    test_back_to_back();
    test_overflow_underflow();
    test_err_clr();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
